sparse_stream_profiler: RTL

//  Passive, synthesizable cycle profiler for one sparse-unit tile (e.g. fiber_access_16).

---
 rtl/sparse_stream_profiler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sparse_stream_profiler.sv
// sparse_stream_profiler
//   Passive cycle profiler for one sparse-unit tile. It only observes the
//   write stream, the read-side input stream and NUM_OUT output streams,
//   and measures how many cycles the write phase and the read phase take.
//   Results stay frozen in DONE until flush or rst.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   clk_en            0 freezes every register
//   flush             synchronous clear to IDLE, gated by clk_en
//   cfg_wait_gap      minimum GAP length before READ may start
//   cfg_out_mask      output channels that must see a done token to end READ
//   wr_*              snooped write stream (token, valid, ready)
//   rd_in_valid       snooped read-side input valid
//   out_*             snooped output streams, channel i at [i*DATA_W +: DATA_W]
//   write_cycles      write-phase cycle count (saturating)
//   read_cycles       read-phase cycle count (saturating)
//   chan_done         per-channel sticky done-token flags
//   state             current phase, encoded as below
//   profile_done      high while in DONE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for the first write valid
// WRITE | counting write cycles until the done token is accepted
// GAP   | waiting cfg_wait_gap cycles and for any read-side activity
// READ  | counting read cycles until every enabled channel saw done
// DONE  | results held until flush or rst
module sparse_stream_profiler #(
    parameter int                DATA_W     = 17,
    parameter int                NUM_OUT    = 2,
    parameter int                CNT_W      = 64,
    parameter int                GAP_W      = 16,
    parameter logic [DATA_W-1:0] DONE_TOKEN = 17'h10100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      flush,
    input  logic [GAP_W-1:0]          cfg_wait_gap,
    input  logic [NUM_OUT-1:0]        cfg_out_mask,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_valid,
    input  logic                      wr_ready,
    input  logic                      rd_in_valid,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [CNT_W-1:0]          write_cycles,
    output logic [CNT_W-1:0]          read_cycles,
    output logic [NUM_OUT-1:0]        chan_done,
    output logic [2:0]                state,
    output logic                      profile_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   write_cycles_q;
    logic [CNT_W-1:0]   read_cycles_q;
    logic [CNT_W-1:0]   write_cycles_d;
    logic [CNT_W-1:0]   read_cycles_d;
    logic [NUM_OUT-1:0] chan_done_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               rd_seen_q;

    logic               wr_done;
    logic [NUM_OUT-1:0] out_done;
    logic               all_done;

    assign wr_done = wr_valid & wr_ready & (wr_data == DONE_TOKEN);

    always_comb begin
        out_done = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_done[i] = out_valid[i] & out_ready[i]
                          & (out_data[i*DATA_W +: DATA_W] == DONE_TOKEN);
        end
    end

    // Registered flags only, so a done handshake is counted in its own cycle
    // and READ exits on the following edge. Masked-off channels count as done.
    assign all_done = &(chan_done_q | ~cfg_out_mask);

    // Saturating increments: hold at all-ones instead of wrapping.
    assign write_cycles_d = (write_cycles_q == '1) ? write_cycles_q
                                                   : write_cycles_q + CNT_W'(1);
    assign read_cycles_d  = (read_cycles_q == '1)  ? read_cycles_q
                                                   : read_cycles_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            write_cycles_q <= '0;
            read_cycles_q  <= '0;
            chan_done_q    <= '0;
            gap_cnt_q      <= '0;
            rd_seen_q      <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                state_q        <= S_IDLE;
                write_cycles_q <= '0;
                read_cycles_q  <= '0;
                chan_done_q    <= '0;
                gap_cnt_q      <= '0;
                rd_seen_q      <= 1'b0;
            end else begin
                if (rd_in_valid) begin
                    rd_seen_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (wr_valid) begin
                            state_q        <= S_WRITE;
                            write_cycles_q <= write_cycles_d;
                        end
                    end
                    S_WRITE: begin
                        write_cycles_q <= write_cycles_d;
                        chan_done_q    <= chan_done_q | out_done;
                        if (wr_done) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= cfg_wait_gap;
                        end
                    end
                    S_GAP: begin
                        chan_done_q <= chan_done_q | out_done;
                        if (gap_cnt_q != '0) begin
                            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                        end else if (rd_seen_q) begin
                            state_q <= S_READ;
                        end
                    end
                    S_READ: begin
                        chan_done_q <= chan_done_q | out_done;
                        if (all_done) begin
                            state_q <= S_DONE;
                        end else begin
                            read_cycles_q <= read_cycles_d;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign write_cycles = write_cycles_q;
    assign read_cycles  = read_cycles_q;
    assign chan_done    = chan_done_q;
    assign state        = state_q;
    assign profile_done = (state_q == S_DONE);

endmodule
